// File: rtl/mem_wb_pkg.sv
// Shared widths and the MEM->WB payload beat for the write-back stage.
package mem_wb_pkg;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int COUNT_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [ADDR_W-1:0] rd;
        logic              mem_to_reg;
        logic              reg_write;
    } mem_wb_beat_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (head + skid) valid/ready buffer with flush; state moves on the falling edge.
module pipe_skid_buf
    import mem_wb_pkg::*;
#(
    parameter type beat_t = mem_wb_beat_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    output logic  in_ready,
    input  beat_t in_beat,
    input  logic  flush,
    input  logic  out_ready,
    output logic  out_valid,
    output beat_t out_beat
);
    logic  h_vld, s_vld;
    beat_t h_beat, s_beat;
    logic  acc, pop;

    assign in_ready  = !s_vld;
    assign out_valid = h_vld;
    assign out_beat  = h_beat;
    assign acc       = in_valid & !s_vld;
    assign pop       = h_vld & out_ready;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_vld  <= 1'b0;
            s_vld  <= 1'b0;
            h_beat <= '0;
            s_beat <= '0;
        end else if (flush) begin
            // payload is left alone; only the valid bits are dropped
            h_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (!h_vld || pop) begin
            if (s_vld) begin
                h_beat <= s_beat;
                s_vld  <= acc;
                if (acc) s_beat <= in_beat;
            end else begin
                h_vld <= acc;
                if (acc) h_beat <= in_beat;
            end
        end else if (acc) begin
            s_vld  <= 1'b1;
            s_beat <= in_beat;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage: skid-buffered handshake, MemToReg select, gated write enable,
// retired write-back counter. Optional forwarding tap under MEM_WB_FWD_EN.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W   = mem_wb_pkg::DATA_W,
    parameter int ADDR_W   = mem_wb_pkg::ADDR_W,
    parameter int COUNT_W  = mem_wb_pkg::COUNT_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  mem_data_in,
    input  logic [DATA_W-1:0]  alu_result_in,
    input  logic [ADDR_W-1:0]  rd_in,
    input  logic               mem_to_reg_in,
    input  logic               reg_write_in,
    input  logic               flush,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  wb_data,
    output logic [ADDR_W-1:0]  wb_addr,
    output logic               wb_we,
    output logic [COUNT_W-1:0] wb_count,
    output logic               fwd_valid,
    output logic [ADDR_W-1:0]  fwd_addr,
    output logic [DATA_W-1:0]  fwd_data
);
    // Local beat type follows the instance widths rather than the package defaults.
    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [ADDR_W-1:0] rd;
        logic              mem_to_reg;
        logic              reg_write;
    } beat_t;

    beat_t in_beat, h_beat;
    logic  h_vld, zero_hit;

    assign in_beat = '{mem_data:   mem_data_in,
                       alu_result: alu_result_in,
                       rd:         rd_in,
                       mem_to_reg: mem_to_reg_in,
                       reg_write:  reg_write_in};

    pipe_skid_buf #(.beat_t(beat_t)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_beat   (in_beat),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (h_vld),
        .out_beat  (h_beat)
    );

    assign out_valid = h_vld;
    assign zero_hit  = ZERO_REG && (h_beat.rd == '0);
    assign wb_data   = h_beat.mem_to_reg ? h_beat.mem_data : h_beat.alu_result;
    assign wb_addr   = h_beat.rd;
    assign wb_we     = h_vld & out_ready & h_beat.reg_write & !zero_hit;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n)     wb_count <= '0;
        else if (wb_we) wb_count <= wb_count + 1'b1;
    end

`ifdef MEM_WB_FWD_EN
    // Tap reflects the held beat regardless of whether write-back is stalled.
    assign fwd_valid = h_vld & h_beat.reg_write & !zero_hit;
    assign fwd_addr  = h_beat.rd;
    assign fwd_data  = wb_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM→WB pipeline stage for the RISC core. It carries load data, ALU result, destination register and write-back controls from the memory stage to the register file, and performs the final MemToReg select. It adds a valid/ready handshake with a two-entry skid buffer, flush-to-bubble, a retired write-back counter and an optional forwarding tap. It sits between the data-memory/ALU outputs and the register-file write port.

## Interface
- DATA_W, 16, width of memory data, ALU result and write-back data
- ADDR_W, 3, register-address width
- COUNT_W, 16, width of the retired write-back counter
- ZERO_REG, 1, when 1, writes to register 0 are suppressed
- clk  in  1  stage clock; all state updates on the falling edge, matching the other pipeline registers
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  memory stage presents a beat
- in_ready  out  1  stage can accept a beat
- mem_data_in  in  DATA_W  data-memory read data
- alu_result_in  in  DATA_W  ALU result
- rd_in  in  ADDR_W  destination register (already rd/rt-muxed)
- mem_to_reg_in  in  1  1 = write back memory data
- reg_write_in  in  1  instruction writes the register file
- flush  in  1  discard all held beats
- out_ready  in  1  write-back side accepts a beat (hazard/stall control)
- out_valid  out  1  head beat present
- wb_data  out  DATA_W  selected write-back data
- wb_addr  out  ADDR_W  write-back register
- wb_we  out  1  register-file write enable
- wb_count  out  COUNT_W  committed write-backs
- fwd_valid / fwd_addr / fwd_data  out  1 / ADDR_W / DATA_W  forwarding tap

## Operation
- Storage: head entry H and skid entry S, each with a valid bit plus {mem_data, alu_result, rd, mem_to_reg, reg_write}.
- Accept: a beat is accepted when in_valid & in_ready at the falling edge. Output pop: occurs when out_valid & out_ready.
- Loading an empty H: the beat goes into H. If H is occupied and not popping, the beat goes into S. Pop with S valid: S moves to H, and any accepted beat goes to S. Order is always preserved.
- in_ready = !S.valid (registered). out_valid = H.valid.
- wb_data = H.mem_to_reg ? H.mem_data : H.alu_result. wb_addr = H.rd.
- wb_we = H.valid & out_ready & H.reg_write & !(ZERO_REG & H.rd==0).
- wb_count increments on every edge where wb_we=1 and wraps modulo 2^COUNT_W. Flush does not clear it.
- Flush clears H.valid and S.valid; an incoming beat on the same edge is dropped (flush wins). Data fields keep their values; only the valid bits matter.
- Bubbles (valid=0) never assert wb_we or fwd_valid.

## Timing
- Latency: a beat accepted at edge N appears on wb_* after edge N when H was empty or popping at N.
- Throughput: one beat per cycle with out_ready held high.
- Stall: with out_ready=0, H is held, S fills, and in_ready drops after the second accepted beat.
- Reset (rst_n low, asynchronous) clears all valid bits, payload, wb_count and every output to 0, except in_ready=1. The cycle after release behaves as empty.
- Reset mid-stream discards all held beats; no write-back is issued for them.
- wb_we and fwd_* are combinational from registered state and out_ready; no input-to-output paths from in_*.

## Configuration
- MEM_WB_FWD_EN defined: fwd_valid = H.valid & H.reg_write & !(ZERO_REG & H.rd==0), fwd_addr = H.rd, fwd_data = wb_data. fwd_valid is independent of out_ready.
- MEM_WB_FWD_EN undefined: the fwd_* ports remain and are tied to 0. No forwarding logic is generated.

## Structure
- Package mem_wb_pkg holds the default widths (DATA_W, ADDR_W, COUNT_W) and the packed payload struct mem_wb_beat_t {mem_data, alu_result, rd, mem_to_reg, reg_write}.
- Sub-module pipe_skid_buf: generic two-entry skid buffer over mem_wb_beat_t, with flush. mem_wb_stage wraps it with the write-back mux, write-enable gating, the counter and the forwarding tap.

## Test plan
- Reset, then stream beats with out_ready=1: send {alu=0x1234, rd=2, mem_to_reg=0, reg_write=1}, then {mem=0xBEEF, rd=5, mem_to_reg=1} → wb_data 0x1234/rd 2, then 0xBEEF/rd 5 on consecutive cycles; wb_count reaches 2.
- Stall: out_ready=0 while sending 3 beats → first two are accepted, in_ready=0 on the third. Raising out_ready then drains them in order, and the third is accepted.
- Flush with H and S full plus in_valid=1 → out_valid=0 and in_ready=1 on the next cycle; wb_we never pulses and wb_count is unchanged.
- Zero register: beat with rd=0, reg_write=1 and ZERO_REG=1 → wb_we=0 and fwd_valid=0. With ZERO_REG=0 → wb_we=1.
- Counter wrap: COUNT_W=4 with 17 committed writes → wb_count=1.
- Async reset asserted between edges with beats held → all outputs are 0 immediately and in_ready=1; with MEM_WB_FWD_EN set, the fwd_* outputs are 0.
